// File: rtl/board_led_ctrl.sv
// ---------------------------------------------------------------------------
// board_led_ctrl
//   Board-level status LED driver placed between the SoC pins and the eight
//   on-board LEDs.
//   - led[7]: RX activity. Each falling (start-bit) edge on uart_rx becomes a
//     blink of STRETCH_CYCLES, followed by at least GAP_CYCLES of forced off.
//   - led[6]: TX activity, same behaviour on uart_tx, fully independent.
//   - led[5:0]: 6-bit Johnson-counter heartbeat chaser. It advances once
//     every 2^CNT_WIDTH cycles while run is high and holds while run is low.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   run      in   chaser enable
//   uart_rx  in   ISP-UART RX pin, asynchronous to clk, idle high
//   uart_tx  in   ISP-UART TX line, treated as asynchronous, idle high
//   led      out  [7]=RX activity, [6]=TX activity, [5:0]=chaser, active-high
//
// STRETCH_CYCLES and GAP_CYCLES must both be >= 1.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// board_led_act
//   One activity channel: 2-flop synchronizer, edge-history flop, and an
//   IDLE/ON/GAP stretcher FSM. All FSM state lives in the packed struct
//   r_act (state, down-counter, pending flag) so it can be probed as a unit.
//
// Ports
//   i_clk   in   system clock
//   i_rst   in   asynchronous, active-high reset
//   i_line  in   raw asynchronous line, idle high
//   o_led   out  registered activity LED bit
// ---------------------------------------------------------------------------
module board_led_act #(
    parameter int STRETCH_CYCLES = 2500000,
    parameter int GAP_CYCLES     = 1250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_led
);

    localparam int MAX_CYC = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef struct packed {
        state_t        state;
        logic [CW-1:0] cnt;
        logic          pend;
    } act_t;

    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic r_led;
    act_t r_act;
    act_t w_act_nxt;
    logic w_event;

    // Falling edge of the synchronized line: history still high, sync now low.
    assign w_event = r_hist & ~r_sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
            r_act   <= '{state: ST_IDLE, cnt: '0, pend: 1'b0};
            r_led   <= 1'b0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_act   <= w_act_nxt;
            // Registered copy of the next state, so the LED changes on the
            // same edge as the FSM and is high for exactly STRETCH_CYCLES.
            r_led   <= (w_act_nxt.state == ST_ON);
        end
    end

    always_comb begin
        w_act_nxt = r_act;
        case (r_act.state)
            ST_IDLE: begin
                if (w_event) begin
                    w_act_nxt.state = ST_ON;
                    w_act_nxt.cnt   = STRETCH_LOAD;
                end
            end
            ST_ON: begin
                // Edges during ON are ignored: no retrigger, no extension.
                if (r_act.cnt == '0) begin
                    w_act_nxt.state = ST_GAP;
                    w_act_nxt.cnt   = GAP_LOAD;
                end else begin
                    w_act_nxt.cnt = r_act.cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (w_event) begin
                    w_act_nxt.pend = 1'b1;
                end
                if (r_act.cnt == '0) begin
                    // An edge landing on the terminal cycle counts as well,
                    // giving back-to-back blinks with no IDLE cycle.
                    if (r_act.pend || w_event) begin
                        w_act_nxt.state = ST_ON;
                        w_act_nxt.cnt   = STRETCH_LOAD;
                    end else begin
                        w_act_nxt.state = ST_IDLE;
                    end
                    w_act_nxt.pend = 1'b0;
                end else begin
                    w_act_nxt.cnt = r_act.cnt - CW'(1);
                end
            end
            default: begin
                w_act_nxt = '{state: ST_IDLE, cnt: '0, pend: 1'b0};
            end
        endcase
    end

    assign o_led = r_led;

endmodule

module board_led_ctrl #(
    parameter int CNT_WIDTH      = 22,
    parameter int STRETCH_CYCLES = 2500000,
    parameter int GAP_CYCLES     = 1250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       uart_rx,
    input  logic       uart_tx,
    output logic [7:0] led
);

    logic [CNT_WIDTH-1:0] r_presc;
    logic [5:0]           r_chaser;
    logic                 w_led_rx;
    logic                 w_led_tx;

    board_led_act #(
        .STRETCH_CYCLES (STRETCH_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES)
    ) u_act_rx (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_line (uart_rx),
        .o_led  (w_led_rx)
    );

    board_led_act #(
        .STRETCH_CYCLES (STRETCH_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES)
    ) u_act_tx (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_line (uart_tx),
        .o_led  (w_led_tx)
    );

    // Heartbeat: the chaser shifts on the edge where the prescaler wraps
    // from all-ones to zero. Dropping run clears the prescaler, so the first
    // shift after run rises is always a full 2^CNT_WIDTH cycles away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc  <= '0;
            r_chaser <= 6'h00;
        end else if (run) begin
            r_presc <= r_presc + CNT_WIDTH'(1);
            if (&r_presc) begin
                r_chaser <= {r_chaser[4:0], ~r_chaser[5]};
            end
        end else begin
            r_presc <= '0;
        end
    end

    assign led = {w_led_rx, w_led_tx, r_chaser};

endmodule

// File: tb/tb_board_led_ctrl.sv
// ---------------------------------------------------------------------------
// tb_board_led_ctrl
//   Directed bench for board_led_ctrl with CNT_WIDTH=3, STRETCH_CYCLES=8,
//   GAP_CYCLES=4. Outputs are sampled 1 time unit after each rising edge;
//   "E0" is the first edge that samples a line low.
// ---------------------------------------------------------------------------
module tb_board_led_ctrl;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       run     = 1'b0;
    logic       uart_rx = 1'b1;
    logic       uart_tx = 1'b1;
    logic [7:0] led;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      nm;
        int         n;
        logic       run;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[9];

    board_led_ctrl #(
        .CNT_WIDTH      (3),
        .STRETCH_CYCLES (8),
        .GAP_CYCLES     (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .led     (led)
    );

    // clock block
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] exp);
        n_cmp++;
        if (led !== exp) begin
            n_fail++;
            $display("FAIL %s: led=%h expected %h at t=%0t", nm, led, exp, $time);
        end
    endtask

    task automatic check_run(input string nm, input logic [7:0] exp, input int n);
        repeat (n) begin
            tick();
            check(nm, exp);
        end
    endtask

    task automatic do_reset();
        run     = 1'b0;
        uart_rx = 1'b1;
        uart_tx = 1'b1;
        rst     = 1'b1;
        #1;
        check("reset_async", 8'h00);
        repeat (5) tick();
        check("reset_hold", 8'h00);
        rst = 1'b0;
    endtask

    // blink start shared by the RX scenarios: low sampled at E0..E2, led[7]
    // rises after E2; returns just after E2 with uart_rx back high
    task automatic rx_frame_start(input string nm);
        uart_rx = 1'b0;
        check_run({nm, "_lat"}, 8'h00, 2);
        check_run({nm, "_rise"}, 8'h80, 1);
        uart_rx = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"ch_c7",   7, 1'b1, 8'h00};
        vecs[1] = '{"ch_c8",   1, 1'b1, 8'h01};
        vecs[2] = '{"ch_c16",  8, 1'b1, 8'h03};
        vecs[3] = '{"ch_c24",  8, 1'b1, 8'h07};
        vecs[4] = '{"ch_c48", 24, 1'b1, 8'h3F};
        vecs[5] = '{"ch_c56",  8, 1'b1, 8'h3E};
        vecs[6] = '{"ch_c95", 39, 1'b1, 8'h20};
        vecs[7] = '{"ch_c96",  1, 1'b1, 8'h00};
        vecs[8] = '{"ch_c104", 8, 1'b1, 8'h01};

        #2;

        // 1: reset and idle
        do_reset();
        check_run("idle", 8'h00, 100);

        // 2: chaser sequence from the table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run = vecs[i].run;
            repeat (vecs[i].n) tick();
            check(vecs[i].nm, vecs[i].exp);
        end
        run = 1'b0;

        // 2b: run dropped at cycle 20 holds the pattern; resume needs 8 full cycles
        do_reset();
        run = 1'b1;
        repeat (20) tick();
        check("rh_c20", 8'h03);
        run = 1'b0;
        check_run("rh_hold", 8'h03, 30);
        run = 1'b1;
        check_run("rh_resume_wait", 8'h03, 7);
        check_run("rh_resume_shift", 8'h07, 1);
        run = 1'b0;

        // 3: single RX frame
        do_reset();
        check_run("s3_pre", 8'h00, 3);
        rx_frame_start("s3");
        check_run("s3_on", 8'h80, 7);
        check_run("s3_gap", 8'h00, 4);
        check_run("s3_idle", 8'h00, 10);

        // 4a: second edge during ON neither retriggers nor extends
        do_reset();
        rx_frame_start("s4a");
        check_run("s4a_on", 8'h80, 2);
        uart_rx = 1'b0;
        check_run("s4a_on", 8'h80, 3);
        uart_rx = 1'b1;
        check_run("s4a_on", 8'h80, 2);
        check_run("s4a_off", 8'h00, 14);

        // 4b: edge during GAP is held pending, GAP still lasts exactly 4
        do_reset();
        rx_frame_start("s4b");
        check_run("s4b_on1", 8'h80, 7);
        check_run("s4b_gap", 8'h00, 1);
        uart_rx = 1'b0;
        check_run("s4b_gap", 8'h00, 3);
        uart_rx = 1'b1;
        check_run("s4b_on2", 8'h80, 8);
        check_run("s4b_gap2", 8'h00, 4);
        check_run("s4b_idle", 8'h00, 10);

        // 4c: edge detected on the GAP terminal cycle re-enters ON at once
        do_reset();
        rx_frame_start("s4c");
        check_run("s4c_on1", 8'h80, 7);
        check_run("s4c_gap", 8'h00, 2);
        uart_rx = 1'b0;
        check_run("s4c_gap", 8'h00, 2);
        check_run("s4c_reon", 8'h80, 1);
        uart_rx = 1'b1;
        check_run("s4c_on2", 8'h80, 7);
        check_run("s4c_gap2", 8'h00, 4);
        check_run("s4c_idle", 8'h00, 10);

        // 5: continuous TX traffic, falling edge every 4 cycles for 200 cycles
        do_reset();
        for (int i = 0; i < 240; i++) begin
            logic [7:0] exp5;
            if (i < 200) uart_tx = ((i / 2) % 2) != 0;
            else         uart_tx = 1'b1;
            tick();
            exp5 = (i >= 2 && (i - 2) < 200 && ((i - 2) % 12) < 8) ? 8'h40 : 8'h00;
            check("s5_tx", exp5);
        end

        // 6: asynchronous reset mid-ON, then quiet lines
        do_reset();
        rx_frame_start("s6");
        check_run("s6_on", 8'h80, 2);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async", 8'h00);
        tick();
        tick();
        check("s6_hold", 8'h00);
        rst = 1'b0;
        check_run("s6_quiet", 8'h00, 50);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/board_led_ctrl.md
Name: board_led_ctrl

Overview:
Board-level status LED driver that sits between the SoC top-level pins and the 8 on-board LEDs. It drives the LEDs directly and replaces raw wiring of the UART lines to the LEDs.
- Detects start-bit edges on the ISP-UART RX and TX lines and stretches each into a visible, rate-limited blink.
- Drives a 6-bit Johnson-counter "heartbeat" chaser showing that the clock is running.

Parameters:
CNT_WIDTH, 22, chaser prescaler width; chaser advances once every 2^CNT_WIDTH cycles.
STRETCH_CYCLES, 2500000, activity LED on-time in clk cycles; must be >= 1.
GAP_CYCLES, 1250000, forced off-time after each blink in clk cycles; must be >= 1.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
run  input  1  chaser enable.
uart_rx  input  1  ISP-UART RX pin; asynchronous to clk; idle high.
uart_tx  input  1  ISP-UART TX line; treated as asynchronous; idle high.
led  output  8  [7]=RX activity, [6]=TX activity, [5:0]=chaser; active-high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - led = 8'h00.
  - Synchronizer flops and edge-history flops = 1 (idle).
  - Activity FSMs = IDLE, counters = 0, pending flags = 0.
  - Prescaler = 0, chaser = 6'h00.
- Reset asserted mid-operation: all of the above take effect immediately, without waiting for a clock edge.
- Input synchronization, per channel:
  - 2-flop synchronizer, then a history flop.
  - event = history & ~sync2, i.e. a 1->0 falling edge.
  - Low pulses shorter than 2 clk periods may be missed; this is accepted.
- Activity FSM, one per channel, independent of the other. States IDLE, ON, GAP:
  - IDLE: on event -> ON, load cnt = STRETCH_CYCLES-1.
  - ON: events ignored; no retrigger, no extension. If cnt == 0 -> GAP, load cnt = GAP_CYCLES-1; else decrement cnt.
  - GAP: an event sets pending. If cnt == 0: if pending or event this cycle -> ON, load STRETCH_CYCLES-1, clear pending; else -> IDLE. Otherwise decrement cnt.
  - LED bit is a registered copy of (next_state == ON). It updates on the same edge as the state, so it is high for exactly STRETCH_CYCLES cycles and low for at least GAP_CYCLES cycles between blinks.
  - Latency: input first sampled low at edge E0 -> led bit high after edge E2.
- Chaser:
  - run = 1: prescaler increments each cycle and wraps modulo 2^CNT_WIDTH. On the edge where the prescaler wraps from all-ones to 0, chaser <= {chaser[4:0], ~chaser[5]}.
  - run = 0: prescaler forced to 0, chaser holds its value.
  - First shift occurs 2^CNT_WIDTH cycles after run rises.
  - Sequence period is 12 shifts.
  - led[5:0] = chaser, registered.
- Simultaneous events: RX and TX paths are fully independent. An event arriving in the same cycle as the GAP terminal count restarts ON with no IDLE cycle.
- Widths: counters sized $clog2 of max(STRETCH_CYCLES, GAP_CYCLES) + 1. No arithmetic overflow is possible.

Test Plan:
All scenarios use CNT_WIDTH=3, STRETCH_CYCLES=8, GAP_CYCLES=4.
1. Reset/idle: rst high 5 cycles, release, run=0, uart lines high for 100 cycles -> led == 8'h00 throughout.
2. Chaser: run=1 after reset.
   - led[5:0] -> 000001 at cycle 8, 000011 at 16, 111111 at 48, 111110 at 56, 000000 at 96.
   - Deassert run at cycle 20 -> holds 000011.
3. Single RX frame: uart_rx low 3 cycles starting at edge E0 -> led[7] high from E2 for exactly 8 cycles, then 0; led[6] stays 0.
4. Retrigger rules, all on RX:
   - Second falling edge during ON -> no extension, ON still 8 cycles.
   - Falling edge during GAP -> led[7] low exactly 4 cycles, then high 8 cycles again.
   - Falling edge coincident with the GAP terminal cycle -> immediate re-ON.
5. Continuous traffic: uart_tx toggles every 2 cycles for 200 cycles -> led[6] repeats 8 high / 4 low; led[7] and chaser unaffected.
6. Async reset mid-ON: assert rst between clock edges while led[7] = 1 -> led == 0 before the next edge. Release with lines held high -> no spurious blink for 50 cycles.
